// File: rtl/issue_scoreboard.sv
// Issue gate between decode and execute.
// Tracks in-flight load destinations and blocks hazards.
module issue_scoreboard #(
  parameter int MAX_LOADS = 2,
  parameter int CNT_W     = 32,
  localparam int LW       = $clog2(MAX_LOADS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [4:0]       rd,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             dest_wen,
  input  logic             is_load,
  input  logic             is_serial,
  input  logic             is_ebreak,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [31:0]      busy,
  output logic [LW-1:0]    load_cnt,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [LW-1:0] MAXC = LW'(MAX_LOADS);

  state_t state;
  logic   issue_ok;
  logic   fire;
  logic   ld_inc;
  logic   ld_dec;
  logic   blk;

  // Hazard and structural checks against registered state only
  always_comb begin
    blk = 1'b0;
    if (use_rs1 && busy[rs1])                blk = 1'b1;
    if (use_rs2 && busy[rs2])                blk = 1'b1;
    if (dest_wen && busy[rd])                blk = 1'b1;
    if (is_load && load_cnt == MAXC)         blk = 1'b1;
    if ((is_serial || is_ebreak) &&
        load_cnt != '0)                      blk = 1'b1;
    if (flush)                               blk = 1'b1;
    issue_ok = (state == RUN) && !rst && !blk;
  end

  assign out_valid = in_valid & issue_ok;
  assign in_ready  = issue_ok & out_ready;
  assign fire      = in_valid & in_ready;
  assign ld_inc    = fire & is_load;
  assign ld_dec    = wb_valid & (load_cnt != '0);

  // Run/halt state; halted is registered alongside it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      unique case (state)
        RUN: if (fire && is_ebreak) begin
          state  <= HALT;
          halted <= 1'b1;
        end
        HALT: begin
          state  <= HALT;
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Scoreboard: set on load issue, clear on writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wb_valid && wb_rd == 5'(i))
          busy[i] <= 1'b0;
        else if (ld_inc && dest_wen && rd == 5'(i))
          busy[i] <= 1'b1;
      end
      busy[0] <= 1'b0;
    end
  end

  // In-flight load count and sticky spurious-writeback flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt <= '0;
      err      <= 1'b0;
    end else begin
      unique case ({ld_inc, ld_dec})
        2'b10:   load_cnt <= load_cnt + 1'b1;
        2'b01:   load_cnt <= load_cnt - 1'b1;
        default: load_cnt <= load_cnt;
      endcase
      if (wb_valid && load_cnt == '0)
        err <= 1'b1;
    end
  end

  // Saturating count of cycles an instruction waits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (in_valid && !issue_ok && !(&stall_cycles))
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule
